// File: rtl/node_path_sequencer.sv
// node_path_sequencer: holds a host-loaded path of 3-bit turn codes and hands
// them to the line follower one node at a time. It counts nodes and parks the
// bot (fault=1, direction=7) once the path is exhausted, a stop code is reached,
// or the host aborts.
// Optional feature: define NODE_WDOG_EN to add a watchdog that trips into a
// sticky WDOG state when no node edge arrives within WDOG_CYCLES clocks in RUN.
module node_path_sequencer #(
  parameter int DEPTH       = 16,
  parameter int CNT_W       = 8,
  parameter int WDOG_CYCLES = 50000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             node_clk,
  input  logic             path_valid,
  input  logic [2:0]       path_dir,
  output logic             path_ready,
  input  logic             start,
  input  logic             abort,
  output logic [2:0]       direction,
  output logic             fault,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] node_cnt,
  output logic             wdog_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [2:0]    DIR_STOP = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE,
    S_WDOG
  } state_t;

  state_t          state;
  logic [2:0]      mem [DEPTH];
  logic [AW:0]     count;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            node_q;

  logic            rise;
  logic            fall;
  logic            accept;
  logic [AW:0]     count_nxt;
  logic [AW-1:0]   rd_ptr_inc;
  logic            last_entry;

  assign rise       = node_clk & ~node_q;
  assign fall       = ~node_clk & node_q;
  // path_ready is a registered output, so it already reflects IDLE/LOAD and space left
  assign accept     = path_valid && path_ready && !rst && !abort;
  assign count_nxt  = count + (AW+1)'(accept);
  assign rd_ptr_inc = rd_ptr + PTR_ONE;
  assign last_entry = ({1'b0, rd_ptr} == (count - CNT_ONE));

`ifdef NODE_WDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(WDOG_CYCLES - 1);
  logic [WW-1:0] wdog_cnt;
`else
  assign wdog_err = 1'b0;
`endif

  // Path storage: data only, written on every accepted beat
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= path_dir;
  end

  // Control FSM with registered outputs; abort behaves exactly like reset
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state      <= S_IDLE;
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      node_q     <= 1'b1;
      direction  <= DIR_STOP;
      fault      <= 1'b1;
      path_ready <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      node_cnt   <= '0;
`ifdef NODE_WDOG_EN
      wdog_cnt   <= '0;
      wdog_err   <= 1'b0;
`endif
    end else begin
      node_q <= node_clk;
      case (state)
        S_IDLE, S_LOAD: begin
          if (accept) begin
            wr_ptr <= wr_ptr + PTR_ONE;
            count  <= count_nxt;
          end
          // LOAD always holds at least one entry, so start is honoured there only
          if (state == S_LOAD && start) begin
            state      <= S_RUN;
            rd_ptr     <= '0;
            direction  <= mem[0];
            fault      <= 1'b0;
            busy       <= 1'b1;
            path_ready <= 1'b0;
            node_cnt   <= '0;
`ifdef NODE_WDOG_EN
            wdog_cnt   <= '0;
`endif
          end else begin
            if (accept) state <= S_LOAD;
            path_ready <= (count_nxt < DEPTH_C);
          end
        end
        S_RUN: begin
          if (rise) node_cnt <= node_cnt + 1'b1;
          // Direction only moves on the trailing edge, so it is stable through the node
          if (fall) begin
            if (last_entry || mem[rd_ptr] == DIR_STOP) begin
              state     <= S_DONE;
              direction <= DIR_STOP;
              fault     <= 1'b1;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              rd_ptr    <= rd_ptr_inc;
              direction <= mem[rd_ptr_inc];
            end
          end
`ifdef NODE_WDOG_EN
          if (rise || fall) begin
            wdog_cnt <= '0;
          end else if (wdog_cnt == WD_LAST) begin
            state     <= S_WDOG;
            direction <= DIR_STOP;
            fault     <= 1'b1;
            busy      <= 1'b0;
            wdog_err  <= 1'b1;
          end else begin
            wdog_cnt <= wdog_cnt + 1'b1;
          end
`endif
        end
        default: begin
          // DONE and WDOG are parked until abort or reset
        end
      endcase
    end
  end

endmodule

// File: tb/tb_node_path_sequencer.sv
// Testbench for node_path_sequencer: a fixed vector table for the basic path,
// hand-written multi-cycle sequences for the corner cases, and a randomized
// run compared against a queue-based reference model.
module tb_node_path_sequencer;

  localparam int DEPTH = 16;
  localparam int CNT_W = 8;
`ifdef NODE_WDOG_EN
  localparam int TB_WDOG = 100;
`else
  localparam int TB_WDOG = 50000000;
`endif

  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_DONE = 3, M_WDOG = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             node_clk = 1'b0;
  logic             path_valid = 1'b0;
  logic [2:0]       path_dir = 3'd0;
  logic             path_ready;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [2:0]       direction;
  logic             fault;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] node_cnt;
  logic             wdog_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int         m_mode = M_IDLE;
  logic [2:0] m_path [$];
  int         m_idx = 0;
  int         m_nodes = 0;
  int         m_wd = 0;
  bit         m_prev = 1'b1;

  typedef struct {
    bit         r, v;
    logic [2:0] d;
    bit         s, a, n;
    bit         e_rdy;
    logic [2:0] e_dir;
    bit         e_flt, e_busy, e_done;
    int         e_cnt;
  } vec_t;

  vec_t tbl [15];

  always #5 clk = ~clk;

  node_path_sequencer #(
    .DEPTH(DEPTH), .CNT_W(CNT_W), .WDOG_CYCLES(TB_WDOG)
  ) dut (
    .clk(clk), .rst(rst), .node_clk(node_clk),
    .path_valid(path_valid), .path_dir(path_dir), .path_ready(path_ready),
    .start(start), .abort(abort), .direction(direction), .fault(fault),
    .busy(busy), .done(done), .node_cnt(node_cnt), .wdog_err(wdog_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input bit rdy, input logic [2:0] dir,
                         input bit flt, input bit bsy, input bit dn, input int cnt);
    chk({tag, "_ready"}, 32'(path_ready), 32'(rdy));
    chk({tag, "_dir"},   32'(direction),  32'(dir));
    chk({tag, "_fault"}, 32'(fault),      32'(flt));
    chk({tag, "_busy"},  32'(busy),       32'(bsy));
    chk({tag, "_done"},  32'(done),       32'(dn));
    chk({tag, "_cnt"},   32'(node_cnt),   32'(cnt));
  endtask

  // Path semantics straight from the rules: a list of codes, an index into it,
  // and a count of rising node flags while running.
  task automatic model_update();
    bit r, f;
    int old;
    if (rst || abort) begin
      m_path.delete();
      m_mode = M_IDLE; m_idx = 0; m_nodes = 0; m_wd = 0; m_prev = 1'b1;
      return;
    end
    r = node_clk && !m_prev;
    f = !node_clk && m_prev;
    m_prev = node_clk;
    old = m_mode;
    if ((old == M_IDLE || old == M_LOAD) && m_path.size() < DEPTH && path_valid) begin
      m_path.push_back(path_dir);
      if (old == M_IDLE) m_mode = M_LOAD;
    end
    if (old == M_LOAD && start) begin
      m_mode = M_RUN; m_idx = 0; m_nodes = 0; m_wd = 0;
    end
    if (old == M_RUN) begin
      if (r) m_nodes = (m_nodes + 1) % (1 << CNT_W);
      if (f) begin
        if (m_idx == m_path.size() - 1 || m_path[m_idx] == 3'd7) m_mode = M_DONE;
        else m_idx++;
      end
`ifdef NODE_WDOG_EN
      if (r || f) m_wd = 0;
      else begin
        m_wd++;
        if (m_wd == TB_WDOG && m_mode == M_RUN) m_mode = M_WDOG;
      end
`endif
    end
  endtask

  task automatic model_check(input int cyc);
    string tag;
    tag = $sformatf("rnd%0d", cyc);
    chk_all(tag, (m_mode == M_IDLE || m_mode == M_LOAD) && m_path.size() < DEPTH,
            (m_mode == M_RUN) ? m_path[m_idx] : 3'd7,
            m_mode != M_RUN, m_mode == M_RUN, m_mode == M_DONE, m_nodes);
    chk({tag, "_wdog"}, 32'(wdog_err), 32'(m_mode == M_WDOG));
  endtask

  // Drive one cycle of inputs (from the falling edge), let the rising edge act,
  // and return at the next falling edge so outputs can be sampled.
  task automatic step(input bit r, input bit v, input logic [2:0] d,
                      input bit s, input bit a, input bit n);
    rst = r; path_valid = v; path_dir = d; start = s; abort = a; node_clk = n;
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 3'd0, 0, 0, node_clk);
  endtask

  task automatic pulse(input int hi, input int lo);
    for (int i = 0; i < hi; i++) step(0, 0, 3'd0, 0, 0, 1);
    for (int i = 0; i < lo; i++) step(0, 0, 3'd0, 0, 0, 0);
  endtask

  initial begin
    int  acc;
    bit  saw1;
    bit  nd;
    int  trip;

    // r v d s a n | rdy dir flt busy done cnt
    tbl[0]  = '{1, 0, 3'd0, 0, 0, 0,  1, 3'd7, 1, 0, 0, 0};
    tbl[1]  = '{0, 1, 3'd0, 0, 0, 0,  1, 3'd7, 1, 0, 0, 0};
    tbl[2]  = '{0, 1, 3'd1, 0, 0, 0,  1, 3'd7, 1, 0, 0, 0};
    tbl[3]  = '{0, 1, 3'd2, 0, 0, 0,  1, 3'd7, 1, 0, 0, 0};
    tbl[4]  = '{0, 0, 3'd0, 1, 0, 0,  0, 3'd0, 0, 1, 0, 0};
    tbl[5]  = '{0, 0, 3'd0, 0, 0, 1,  0, 3'd0, 0, 1, 0, 1};
    tbl[6]  = '{0, 0, 3'd0, 0, 0, 1,  0, 3'd0, 0, 1, 0, 1};
    tbl[7]  = '{0, 0, 3'd0, 0, 0, 0,  0, 3'd1, 0, 1, 0, 1};
    tbl[8]  = '{0, 0, 3'd0, 0, 0, 1,  0, 3'd1, 0, 1, 0, 2};
    tbl[9]  = '{0, 0, 3'd0, 0, 0, 0,  0, 3'd2, 0, 1, 0, 2};
    tbl[10] = '{0, 0, 3'd0, 0, 0, 1,  0, 3'd2, 0, 1, 0, 3};
    tbl[11] = '{0, 0, 3'd0, 0, 0, 0,  0, 3'd7, 1, 0, 1, 3};
    tbl[12] = '{0, 0, 3'd0, 0, 0, 1,  0, 3'd7, 1, 0, 1, 3};
    tbl[13] = '{0, 0, 3'd0, 0, 0, 0,  0, 3'd7, 1, 0, 1, 3};
    tbl[14] = '{0, 0, 3'd0, 0, 1, 0,  1, 3'd7, 1, 0, 0, 0};

    @(negedge clk);

    // Basic three-entry path
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].s, tbl[i].a, tbl[i].n);
      chk_all($sformatf("t1_row%0d", i), tbl[i].e_rdy, tbl[i].e_dir,
              tbl[i].e_flt, tbl[i].e_busy, tbl[i].e_done, tbl[i].e_cnt);
    end
    chk("t1_wdog", 32'(wdog_err), 32'(0));

    // Overfill: 17 beats offered, 16 taken, then all 16 executed
    step(1, 0, 3'd0, 0, 0, 0);
    acc = 0;
    for (int i = 0; i < 17; i++) begin
      if (path_ready === 1'b1) acc++;
      step(0, 1, 3'(i % 3), 0, 0, 0);
      if (i == 15) chk("t2_ready_after16", 32'(path_ready), 32'(0));
    end
    chk("t2_accepted", 32'(acc), 32'(16));
    step(0, 0, 3'd0, 1, 0, 0);
    chk("t2_busy", 32'(busy), 32'(1));
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t2_dir%0d", i), 32'(direction), 32'(i % 3));
      pulse(2, 1);
    end
    chk_all("t2_end", 0, 3'd7, 1, 0, 1, 16);

    // Stop code ends the path early; the entry after it never shows
    step(1, 0, 3'd0, 0, 0, 0);
    step(0, 1, 3'd0, 0, 0, 0);
    step(0, 1, 3'd7, 0, 0, 0);
    step(0, 1, 3'd1, 0, 0, 0);
    step(0, 0, 3'd0, 1, 0, 0);
    saw1 = 1'b0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 4; i++) begin
        step(0, 0, 3'd0, 0, 0, i < 3);
        if (direction === 3'd1) saw1 = 1'b1;
        if (p == 0 && i == 3) chk_all("t3_mid", 0, 3'd7, 0, 1, 0, 1);
      end
    end
    chk_all("t3_end", 0, 3'd7, 1, 0, 1, 2);
    chk("t3_saw_entry2", 32'(saw1), 32'(0));

    // abort together with a node rise
    step(1, 0, 3'd0, 0, 0, 0);
    step(0, 1, 3'd0, 0, 0, 0);
    step(0, 1, 3'd1, 0, 0, 0);
    step(0, 0, 3'd0, 1, 0, 0);
    pulse(2, 1);
    chk_all("t4_pre", 0, 3'd1, 0, 1, 0, 1);
    step(0, 0, 3'd0, 0, 1, 1);
    chk_all("t4_abort", 1, 3'd7, 1, 0, 0, 0);
    step(0, 0, 3'd0, 0, 0, 1);
    chk_all("t4_after", 1, 3'd7, 1, 0, 0, 0);

    // start with an empty path, node pulses in IDLE
    step(1, 0, 3'd0, 0, 0, 0);
    step(0, 0, 3'd0, 1, 0, 0);
    chk_all("t5_start", 1, 3'd7, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) pulse(3, 2);
    chk_all("t5_nodes", 1, 3'd7, 1, 0, 0, 0);

`ifdef NODE_WDOG_EN
    // Watchdog: no node events after start
    step(1, 0, 3'd0, 0, 0, 0);
    step(0, 1, 3'd2, 0, 0, 0);
    step(0, 0, 3'd0, 1, 0, 0);
    trip = -1;
    for (int i = 1; i <= TB_WDOG + 10 && trip < 0; i++) begin
      step(0, 0, 3'd0, 0, 0, 0);
      if (wdog_err === 1'b1) trip = i;
    end
    chk("t6_trip_cycle", 32'(trip), 32'(TB_WDOG));
    idle(5);
    chk("t6_wdog_held", 32'(wdog_err), 32'(1));
    chk("t6_fault", 32'(fault), 32'(1));
    chk("t6_dir", 32'(direction), 32'(7));
    chk("t6_busy", 32'(busy), 32'(0));
    step(0, 0, 3'd0, 0, 1, 0);
    chk("t6_cleared", 32'(wdog_err), 32'(0));
`else
    trip = 0;
    idle(2);
    chk("t6_wdog_tied", 32'(wdog_err), 32'(0));
`endif

    // Randomized traffic against the reference model
    step(1, 0, 3'd0, 0, 0, 0);
    nd = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      bit r, v, s, a;
      logic [2:0] d;
      if ($urandom_range(2, 0) == 0) nd = ~nd;
      r = ($urandom_range(149, 0) == 0);
      a = ($urandom_range(59, 0) == 0);
      s = ($urandom_range(7, 0) == 0);
      v = $urandom_range(1, 0);
      d = ($urandom_range(9, 0) == 0) ? 3'd7 : 3'($urandom_range(6, 0));
      step(r, v, d, s, a, nd);
      model_check(c);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
